sprite_compositor: RTL

- Sits directly downstream of the per-object sprite generators, such as the heart break-apart sprite.
- Takes up to NUM_LAYERS in_sprite/pixel pairs on the shared hcount/vcount raster and priority-merges them over a background colour.
- Applies a frame-synchronous damage-flash effect when a hit event is received.
- Outputs a registered pixel stream with realigned raster coordinates for the video output stage.

---
 rtl/sprite_compositor_if.sv | 30 +++
 rtl/sprite_compositor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor_if.sv
`default_nettype none
// sprite_compositor_if: raster, layer and pixel-stream signals between the sprite generators,
// the compositor and the video output stage.
interface sprite_compositor_if #(
  parameter int NUM_LAYERS = 4
);
  logic [10:0]              hcount_in;
  logic [9:0]               vcount_in;
  logic                     valid_in;
  logic [NUM_LAYERS-1:0]    layer_in_sprite;
  logic [12*NUM_LAYERS-1:0] layer_pixel;
  logic                     hit_in;

  logic [10:0]              hcount_out;
  logic [9:0]               vcount_out;
  logic                     valid_out;
  logic [11:0]              pixel_out;
  logic                     flashing_out;

  modport master (
    output hcount_in, vcount_in, valid_in, layer_in_sprite, layer_pixel, hit_in,
    input  hcount_out, vcount_out, valid_out, pixel_out, flashing_out
  );

  modport slave (
    input  hcount_in, vcount_in, valid_in, layer_in_sprite, layer_pixel, hit_in,
    output hcount_out, vcount_out, valid_out, pixel_out, flashing_out
  );
endinterface
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// sprite_compositor: 2-stage priority merge of sprite layers over a background, with a frame-synchronous
// damage flash. Define SPRITE_COMPOSITOR_BLEND_EN to make layer 0 50% translucent over the next active layer.
module sprite_compositor #(
  parameter int          NUM_LAYERS   = 4,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] FLASH_COLOR  = 12'hF00,
  parameter int          FLASH_FRAMES = 30,
  parameter int          BLINK_PERIOD = 4
) (
  input logic                clk,
  input logic                rst,
  sprite_compositor_if.slave bus
);

  localparam int               CNT_W      = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLASH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              retrig_q, retrig_d;
  logic              flashing_q;

  logic [10:0]       s1_hcount_q;
  logic [9:0]        s1_vcount_q;
  logic              s1_valid_q;
  logic [11:0]       s1_pix_q, s1_pix_d;
  logic              s1_hit_q, s1_hit_d;

  logic [10:0]       out_hcount_q;
  logic [9:0]        out_vcount_q;
  logic              out_valid_q;
  logic [11:0]       out_pix_q, out_pix_d;

  logic              frame_start;
  logic              blink_on;

  assign frame_start = bus.valid_in && (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  assign blink_on    = ((32'(frame_cnt_q) / 32'(BLINK_PERIOD)) % 32'd2) == 32'd0;

`ifdef SPRITE_COMPOSITOR_BLEND_EN
  logic [11:0] low_pix;
  logic        low_hit;

  function automatic logic [3:0] avg4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[4:1];
  endfunction

  // Highest-priority active layer underneath layer 0.
  always_comb begin
    low_pix = BG_COLOR;
    low_hit = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 1; i--) begin
      if (bus.layer_in_sprite[i]) begin
        low_pix = bus.layer_pixel[12*i +: 12];
        low_hit = 1'b1;
      end
    end
  end
`endif

  // Scanning from the lowest priority upward leaves the lowest active index selected.
  always_comb begin
    s1_pix_d = BG_COLOR;
    s1_hit_d = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layer_in_sprite[i]) begin
        s1_pix_d = bus.layer_pixel[12*i +: 12];
        s1_hit_d = 1'b1;
      end
    end
`ifdef SPRITE_COMPOSITOR_BLEND_EN
    if (bus.layer_in_sprite[0] && low_hit) begin
      s1_pix_d = {avg4(bus.layer_pixel[11:8], low_pix[11:8]),
                  avg4(bus.layer_pixel[7:4],  low_pix[7:4]),
                  avg4(bus.layer_pixel[3:0],  low_pix[3:0])};
    end
`endif
  end

  // The FSM register changes on the frame-start pixel's stage-1 edge, so every pixel of that frame
  // reaches stage 2 under the new state.
  always_comb begin
    out_pix_d = 12'h000;
    if (s1_valid_q) begin
      if (s1_hit_q && (state_q == FLASH) && blink_on) begin
        out_pix_d = FLASH_COLOR;
      end else begin
        out_pix_d = s1_pix_q;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    retrig_d    = retrig_q;
    case (state_q)
      IDLE: begin
        if (bus.hit_in) begin
          if (frame_start) begin
            state_d     = FLASH;
            frame_cnt_d = '0;
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (frame_start) begin
          state_d     = FLASH;
          frame_cnt_d = '0;
        end
      end
      FLASH: begin
        if (frame_start) begin
          if (retrig_q || bus.hit_in) begin
            frame_cnt_d = '0;
            retrig_d    = 1'b0;
          end else if (frame_cnt_q == LAST_FRAME) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end else if (bus.hit_in) begin
          retrig_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        frame_cnt_d = '0;
        retrig_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      retrig_q     <= 1'b0;
      flashing_q   <= 1'b0;
      s1_hcount_q  <= '0;
      s1_vcount_q  <= '0;
      s1_valid_q   <= 1'b0;
      s1_pix_q     <= '0;
      s1_hit_q     <= 1'b0;
      out_hcount_q <= '0;
      out_vcount_q <= '0;
      out_valid_q  <= 1'b0;
      out_pix_q    <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      retrig_q     <= retrig_d;
      flashing_q   <= (state_d == FLASH);
      s1_hcount_q  <= bus.hcount_in;
      s1_vcount_q  <= bus.vcount_in;
      s1_valid_q   <= bus.valid_in;
      s1_pix_q     <= s1_pix_d;
      s1_hit_q     <= s1_hit_d;
      out_hcount_q <= s1_hcount_q;
      out_vcount_q <= s1_vcount_q;
      out_valid_q  <= s1_valid_q;
      out_pix_q    <= out_pix_d;
    end
  end

  assign bus.hcount_out   = out_hcount_q;
  assign bus.vcount_out   = out_vcount_q;
  assign bus.valid_out    = out_valid_q;
  assign bus.pixel_out    = out_pix_q;
  assign bus.flashing_out = flashing_q;

endmodule
`default_nettype wire
